a_send_ch_ctrl: RTL and testbench

A_SEND_CH_CTRL -- requirements
Module: a_send_ch_ctrl

---
 rtl/a_send_ch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_a_send_ch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a_send_ch_ctrl.sv
// a_send_ch_ctrl
// NCH independent send channels. Each channel captures its adata slice on
// an accepted send, flips its areq toggle, then waits in BUSY for an ack.
// An optional timeout, latched per transfer from timeout_cyc, moves the
// channel to ERR. ERR is left only through aerr_clr.
//
// Ports
//   aclk         in   1        clock, rising edge
//   arst_n       in   1        asynchronous active-low reset
//   asend        in   NCH      per-channel send request (used in READY only)
//   adata        in   NCH*DW   send data, channel i at [i*DW +: DW]
//   aack         in   NCH      ack, pulse (ACK_MODE=0) or toggle (ACK_MODE=1)
//   timeout_cyc  in   TO_W     ack timeout in cycles, 0 = no timeout
//   aerr_clr     in   NCH      per-channel error clear
//   aready       out  NCH      channel is READY
//   areq         out  NCH      request toggle, flips once per accepted send
//   ahold        out  NCH*DW   data captured by the last accepted send
//   aerr         out  NCH      channel is in ERR
module a_send_ch_ctrl #(
   parameter int DW       = 8,
   parameter int NCH      = 4,
   parameter int TO_W     = 8,
   parameter int ACK_MODE = 1
) (
   input  logic                aclk,
   input  logic                arst_n,
   input  logic [NCH-1:0]      asend,
   input  logic [NCH*DW-1:0]   adata,
   input  logic [NCH-1:0]      aack,
   input  logic [TO_W-1:0]     timeout_cyc,
   input  logic [NCH-1:0]      aerr_clr,
   output logic [NCH-1:0]      aready,
   output logic [NCH-1:0]      areq,
   output logic [NCH*DW-1:0]   ahold,
   output logic [NCH-1:0]      aerr
);

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1'b1);
   localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

   state_t              state_q [NCH];
   state_t              state_d [NCH];
   logic [TO_W-1:0]     timer_q [NCH];
   logic [TO_W-1:0]     timer_d [NCH];
   logic [TO_W-1:0]     limit_q [NCH];
   logic [TO_W-1:0]     limit_d [NCH];
   logic [NCH-1:0]      areq_q;
   logic [NCH-1:0]      areq_d;
   logic [NCH-1:0]      ack_q;
   logic [NCH-1:0]      ack_d;
   logic [NCH*DW-1:0]   ahold_q;
   logic [NCH*DW-1:0]   ahold_d;
   logic [NCH-1:0]      ack_ev_s;

   // Ack event decode: a level in pulse mode, a change against the
   // registered copy in toggle mode.
   always_comb begin
      ack_ev_s = {NCH{1'b0}};
      if (ACK_MODE == 0) begin
         ack_ev_s = aack;
      end else begin
         ack_ev_s = aack ^ ack_q;
      end
   end

   // Per-channel next-state and datapath logic.
   always_comb begin
      areq_d  = areq_q;
      ahold_d = ahold_q;
      // The ack copy tracks aack every cycle regardless of state, so a
      // toggle seen while in ERR is not mistaken for an ack later.
      ack_d   = aack;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         timer_d[i] = timer_q[i];
         limit_d[i] = limit_q[i];
         case (state_q[i])
            ST_READY: begin
               if (asend[i]) begin
                  state_d[i]             = ST_BUSY;
                  ahold_d[i*DW +: DW]    = adata[i*DW +: DW];
                  areq_d[i]              = ~areq_q[i];
                  timer_d[i]             = TO_ZERO;
                  limit_d[i]             = timeout_cyc;
               end else begin
                  state_d[i] = ST_READY;
               end
            end
            ST_BUSY: begin
               if (ack_ev_s[i]) begin
                  // Ack wins over a timeout expiring in the same cycle.
                  state_d[i] = ST_READY;
               end else begin
                  if (timer_q[i] != TO_MAX) begin
                     timer_d[i] = timer_q[i] + TO_ONE;
                  end else begin
                     timer_d[i] = timer_q[i];
                  end
                  // The timer counts completed BUSY cycles, so reaching
                  // limit-1 here means this is the limit-th cycle.
                  if ((limit_q[i] != TO_ZERO) && (timer_q[i] == (limit_q[i] - TO_ONE))) begin
                     state_d[i] = ST_ERR;
                  end else begin
                     state_d[i] = ST_BUSY;
                  end
               end
            end
            ST_ERR: begin
               if (aerr_clr[i]) begin
                  state_d[i] = ST_READY;
               end else begin
                  state_d[i] = ST_ERR;
               end
            end
            default: begin
               state_d[i] = ST_READY;
            end
         endcase
      end
   end

   // State, timer, limit, toggle, ack copy and data hold registers.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_READY;
            timer_q[i] <= TO_ZERO;
            limit_q[i] <= TO_ZERO;
         end
         areq_q  <= {NCH{1'b0}};
         ack_q   <= {NCH{1'b0}};
         ahold_q <= {(NCH*DW){1'b0}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
            limit_q[i] <= limit_d[i];
         end
         areq_q  <= areq_d;
         ack_q   <= ack_d;
         ahold_q <= ahold_d;
      end
   end

   // Status outputs decoded straight from the state registers.
   always_comb begin
      aready = {NCH{1'b0}};
      aerr   = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         aready[i] = (state_q[i] == ST_READY);
         aerr[i]   = (state_q[i] == ST_ERR);
      end
   end

   assign areq  = areq_q;
   assign ahold = ahold_q;

endmodule

// File: tb/tb_a_send_ch_ctrl.sv
// Scoreboard bench for a_send_ch_ctrl. Two instances share the send, data,
// timeout and clear inputs: u_tgl uses toggle acks, u_pls uses pulse acks.
// A transaction-level model predicts each channel's outputs per cycle and
// pushes them into a queue; a monitor pops and compares after every edge.
module tb_a_send_ch_ctrl;

   localparam int NCH  = 4;
   localparam int DW   = 8;
   localparam int TO_W = 8;

   logic                aclk = 1'b0;
   logic                arst_n = 1'b0;
   logic [NCH-1:0]      asend = '0;
   logic [NCH*DW-1:0]   adata = '0;
   logic [NCH-1:0]      aack_t = '0;
   logic [NCH-1:0]      aack_p = '0;
   logic [TO_W-1:0]     timeout_cyc = '0;
   logic [NCH-1:0]      aerr_clr = '0;

   logic [NCH-1:0]      rdy_t, req_t, err_t, rdy_p, req_p, err_p;
   logic [NCH*DW-1:0]   hold_t, hold_p;

   a_send_ch_ctrl #(.DW(DW), .NCH(NCH), .TO_W(TO_W), .ACK_MODE(1)) u_tgl (
      .aclk(aclk), .arst_n(arst_n), .asend(asend), .adata(adata), .aack(aack_t),
      .timeout_cyc(timeout_cyc), .aerr_clr(aerr_clr),
      .aready(rdy_t), .areq(req_t), .ahold(hold_t), .aerr(err_t));

   a_send_ch_ctrl #(.DW(DW), .NCH(NCH), .TO_W(TO_W), .ACK_MODE(0)) u_pls (
      .aclk(aclk), .arst_n(arst_n), .asend(asend), .adata(adata), .aack(aack_p),
      .timeout_cyc(timeout_cyc), .aerr_clr(aerr_clr),
      .aready(rdy_p), .areq(req_p), .ahold(hold_p), .aerr(err_p));

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [NCH-1:0]    rdy;
      logic [NCH-1:0]    req;
      logic [NCH-1:0]    err;
      logic [NCH*DW-1:0] hold;
   } snap_t;

   typedef struct packed {
      snap_t t;
      snap_t p;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   rel_pending = 1'b0;

   // Model: 0 idle, 1 waiting for ack, 2 timed out. [0]=toggle dut, [1]=pulse dut.
   int                m_st  [2][NCH];
   int                m_el  [2][NCH];
   int                m_lim [2][NCH];
   logic [NCH-1:0]    m_req [2];
   logic [NCH*DW-1:0] m_hold[2];
   logic [NCH-1:0]    m_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            m_st[d][c] = 0; m_el[d][c] = 0; m_lim[d][c] = 0;
         end
         m_req[d] = '0; m_hold[d] = '0;
      end
      m_seen = '0;
   endtask

   function automatic snap_t model_snap(input int d);
      snap_t s;
      s.req  = m_req[d];
      s.hold = m_hold[d];
      for (int c = 0; c < NCH; c++) begin
         s.rdy[c] = (m_st[d][c] == 0);
         s.err[c] = (m_st[d][c] == 2);
      end
      return s;
   endfunction

   // One cycle: drive inputs at the falling edge, advance the model, queue the prediction.
   task automatic step(input logic [NCH-1:0] s, input logic [NCH*DW-1:0] dat,
                       input logic [NCH-1:0] at, input logic [NCH-1:0] ap,
                       input logic [TO_W-1:0] t, input logic [NCH-1:0] clr);
      exp_t e;
      bit   ev;
      @(negedge aclk);
      if (rel_pending) begin
         arst_n = 1'b1;
         rel_pending = 1'b0;
      end
      asend = s; adata = dat; aack_t = at; aack_p = ap; timeout_cyc = t; aerr_clr = clr;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            ev = (d == 1) ? ap[c] : (at[c] != m_seen[c]);
            if (m_st[d][c] == 0) begin
               if (s[c]) begin
                  m_st[d][c] = 1;
                  m_hold[d][c*DW +: DW] = dat[c*DW +: DW];
                  m_req[d][c] = ~m_req[d][c];
                  m_el[d][c] = 0;
                  m_lim[d][c] = int'(t);
               end
            end else if (m_st[d][c] == 1) begin
               if (ev) begin
                  m_st[d][c] = 0;
               end else begin
                  m_el[d][c]++;
                  if (m_lim[d][c] != 0 && m_el[d][c] >= m_lim[d][c]) m_st[d][c] = 2;
               end
            end else begin
               if (clr[c]) m_st[d][c] = 0;
            end
         end
      end
      m_seen = at;
      e.t = model_snap(0);
      e.p = model_snap(1);
      q.push_back(e);
   endtask

   task automatic chk_reset_vals();
      chk("reset_tgl", 64'({rdy_t, req_t, err_t, hold_t}), 64'({4'hF, 4'h0, 4'h0, 32'h0}));
      chk("reset_pls", 64'({rdy_p, req_p, err_p, hold_p}), 64'({4'hF, 4'h0, 4'h0, 32'h0}));
   endtask

   // Assert reset asynchronously; release happens on the next step.
   task automatic do_reset();
      @(negedge aclk);
      #2;
      arst_n = 1'b0;
      q.delete();
      model_reset();
      #1 chk_reset_vals();
      repeat (3) begin
         @(negedge aclk);
         #1 chk_reset_vals();
      end
      rel_pending = 1'b1;
   endtask

   // Monitor: compare both instances against the queued prediction after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge aclk);
         #1;
         if (arst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_tgl", 64'({rdy_t, req_t, err_t, hold_t}), 64'(e.t));
            chk("sb_pls", 64'({rdy_p, req_p, err_p, hold_p}), 64'(e.p));
         end
      end
   end

   logic [NCH-1:0]  at_lv;
   logic [TO_W-1:0] tmo;

   initial begin
      at_lv = '0;
      tmo = '0;
      model_reset();
      do_reset();

      // Send on channel 0 on the first edge after release.
      step(4'b0001, 32'h0000_00A5, at_lv, '0, tmo, '0);
      @(posedge aclk);
      #2;
      chk("send0_ready", 64'(rdy_t), 64'(4'b1110));
      chk("send0_req",   64'(req_t), 64'(4'b0001));
      chk("send0_hold",  64'(hold_t[7:0]), 64'(8'hA5));

      // Ack three cycles later, then a second send.
      repeat (2) step('0, 32'h1111_1111, at_lv, '0, tmo, '0);
      at_lv[0] = ~at_lv[0];
      step('0, '0, at_lv, 4'b0001, tmo, '0);
      step('0, '0, at_lv, '0, tmo, '0);
      step(4'b0001, 32'h0000_003C, at_lv, '0, tmo, '0);
      at_lv[0] = ~at_lv[0];
      step('0, '0, at_lv, 4'b0001, tmo, '0);

      // Timeout of 5 on channel 2, then clear.
      tmo = 8'd5;
      step(4'b0100, 32'h0077_0000, at_lv, '0, tmo, '0);
      repeat (6) step(4'b0100, 32'hFFFF_FFFF, at_lv, '0, tmo, '0);
      step('0, '0, at_lv, '0, tmo, 4'b0100);
      step('0, '0, at_lv, '0, tmo, '0);

      // Ack arriving exactly in the expiry cycle.
      step(4'b0100, 32'h0099_0000, at_lv, '0, tmo, '0);
      repeat (4) step('0, '0, at_lv, '0, tmo, '0);
      at_lv[2] = ~at_lv[2];
      step('0, '0, at_lv, 4'b0100, tmo, '0);
      step('0, '0, at_lv, '0, tmo, '0);

      // Channel 1 send held high with changing data.
      tmo = 8'd0;
      for (int k = 0; k < 24; k++) begin
         logic [NCH-1:0] ap;
         ap = '0;
         if (k % 4 == 3) begin
            at_lv[1] = ~at_lv[1];
            ap[1] = 1'b1;
         end
         step(4'b0010, 32'($urandom), at_lv, ap, tmo, '0);
      end

      // Randomised traffic.
      for (int k = 0; k < 400; k++) begin
         logic [NCH-1:0] tg, ap;
         tg = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
         ap = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
         at_lv = at_lv ^ tg;
         step(NCH'($urandom), 32'($urandom), at_lv, ap,
              TO_W'($urandom_range(0, 7)), NCH'($urandom) & NCH'($urandom));
      end

      // No timeout, channel 3 busy for 100 cycles, then reset.
      step('0, '0, at_lv, '0, 8'd0, 4'b1111);
      step('0, '0, at_lv, '0, 8'd0, '0);
      step(4'b1000, 32'hC300_0000, at_lv, '0, 8'd0, '0);
      repeat (100) step('0, '0, at_lv, '0, 8'd0, '0);
      do_reset();
      step('0, '0, at_lv, '0, 8'd0, '0);
      @(posedge aclk);
      #2;
      chk("post_rst_ready", 64'({rdy_t, rdy_p}), 64'(8'hFF));
      chk("post_rst_req",   64'({req_t, req_p}), 64'(8'h00));
      repeat (5) step('0, '0, at_lv, '0, 8'd0, '0);

      @(posedge aclk);
      #3;
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
